// File: rtl/priority_isr_ctrl.sv
// priority_isr_ctrl: rotating-priority interrupt resolver holding IRR/ISR; optional AUTO_EOI_EN adds auto_eoi
module priority_isr_ctrl #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               level_trigger,
  input  logic [NUM_IRQ-1:0] interrupt_mask,
  input  logic               special_mask_en,
  input  logic               auto_rotate_en,
  input  logic               int_ack,
  input  logic               eoi_nonspecific,
  input  logic               eoi_specific,
  input  logic               set_priority,
  input  logic [ID_W-1:0]    eoi_level,
`ifdef AUTO_EOI_EN
  input  logic               auto_eoi,
`endif
  output logic               int_req,
  output logic [ID_W-1:0]    int_vector_id,
  output logic               spurious,
  output logic [NUM_IRQ-1:0] irr,
  output logic [NUM_IRQ-1:0] isr
);
  logic [NUM_IRQ-1:0] irq_q, ack_clr, set, clr, irr_n, isr_n;
  logic [ID_W-1:0] lp, lp_n;
  logic [ID_W:0] win, top, win_n;
  logic lvl_ok, ack_w, auto_done;
  // Walks levels from lp+1 cyclically; in normal mode the first blocking bit stops the search.
  function automatic logic [ID_W:0] resolve(input logic [NUM_IRQ-1:0] cand, input logic [NUM_IRQ-1:0] blk,
                                            input logic [ID_W-1:0] p, input logic smm);
    logic done;
    logic [ID_W:0] r, s;
    logic [ID_W-1:0] idx;
    r = '0;
    done = 1'b0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      s = {1'b0, p} + (ID_W+1)'(k + 1);
      if (s >= (ID_W+1)'(NUM_IRQ)) s = s - (ID_W+1)'(NUM_IRQ);
      idx = s[ID_W-1:0];
      if (!done && cand[idx] && !blk[idx]) begin
        r = {1'b1, idx};
        done = 1'b1;
      end else if (!done && blk[idx] && !smm) done = 1'b1;
    end
    return r;
  endfunction
  always_comb begin
    win = resolve(irr & ~interrupt_mask, isr, lp, special_mask_en);
    top = resolve(isr, '0, lp, 1'b1);
    lvl_ok = {1'b0, eoi_level} < (ID_W+1)'(NUM_IRQ);
    ack_w = int_ack && win[ID_W];
`ifdef AUTO_EOI_EN
    auto_done = ack_w && auto_eoi;
`else
    auto_done = 1'b0;
`endif
    ack_clr = ack_w ? NUM_IRQ'(1) << win[ID_W-1:0] : '0;
    set = auto_done ? '0 : ack_clr;
    clr = eoi_nonspecific ? (top[ID_W] ? NUM_IRQ'(1) << top[ID_W-1:0] : '0)
        : (eoi_specific && lvl_ok) ? NUM_IRQ'(1) << eoi_level : '0;
    isr_n = (isr & ~clr) | set;
    irr_n = level_trigger ? irq_in : (irr & ~ack_clr) | (irq_in & ~irq_q);
    lp_n = (set_priority && lvl_ok) ? eoi_level
         : (auto_done && auto_rotate_en) ? win[ID_W-1:0]
         : (eoi_nonspecific && top[ID_W] && auto_rotate_en) ? top[ID_W-1:0] : lp;
    win_n = resolve(irr_n & ~interrupt_mask, isr_n, lp_n, special_mask_en);
  end
  // After an ack the request reflects the post-ack state so it drops in the next cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      irq_q <= '0;
      irr <= '0;
      isr <= '0;
      lp <= ID_W'(NUM_IRQ - 1);
      int_req <= 1'b0;
      int_vector_id <= '0;
      spurious <= 1'b0;
    end else begin
      irq_q <= irq_in;
      irr <= irr_n;
      isr <= isr_n;
      lp <= lp_n;
      int_req <= int_ack ? |win_n : win[ID_W];
      if (int_ack) begin
        int_vector_id <= win[ID_W] ? win[ID_W-1:0] : ID_W'(NUM_IRQ - 1);
        spurious <= !win[ID_W];
      end
    end
  end
endmodule

// File: tb/tb_priority_isr_ctrl.sv
// tb_priority_isr_ctrl: directed scoreboard bench for priority_isr_ctrl (8- and 16-line instances)
module tb_priority_isr_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] irq, mask, irr, isr;
  logic lvl, smm, rot, ack, eoi_ns, eoi_sp, setp, req, spur;
  logic [2:0] lvl_id, vec;
  logic [15:0] b_irq, b_irr, b_isr;
  logic b_ack, b_eoi_sp, b_setp, b_req, b_spur;
  logic [3:0] b_lvl, b_vec;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct { int cyc; int f; logic [31:0] v; string nm; } ent_t;
  ent_t sb[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  priority_isr_ctrl dut (
    .clock(clk), .reset(rst), .irq_in(irq), .level_trigger(lvl), .interrupt_mask(mask),
    .special_mask_en(smm), .auto_rotate_en(rot), .int_ack(ack), .eoi_nonspecific(eoi_ns),
    .eoi_specific(eoi_sp), .set_priority(setp), .eoi_level(lvl_id),
`ifdef AUTO_EOI_EN
    .auto_eoi(1'b0),
`endif
    .int_req(req), .int_vector_id(vec), .spurious(spur), .irr(irr), .isr(isr));
  priority_isr_ctrl #(.NUM_IRQ(16), .ID_W(4)) dut16 (
    .clock(clk), .reset(rst), .irq_in(b_irq), .level_trigger(1'b0), .interrupt_mask(16'h0),
    .special_mask_en(1'b0), .auto_rotate_en(1'b0), .int_ack(b_ack), .eoi_nonspecific(1'b0),
    .eoi_specific(b_eoi_sp), .set_priority(b_setp), .eoi_level(b_lvl),
`ifdef AUTO_EOI_EN
    .auto_eoi(1'b0),
`endif
    .int_req(b_req), .int_vector_id(b_vec), .spurious(b_spur), .irr(b_irr), .isr(b_isr));
  function automatic logic [31:0] act(input int f);
    case (f)
      0: return {24'h0, irr};
      1: return {24'h0, isr};
      2: return {31'h0, req};
      3: return {29'h0, vec};
      4: return {31'h0, spur};
      5: return {16'h0, b_irr};
      6: return {16'h0, b_isr};
      7: return {31'h0, b_req};
      8: return {28'h0, b_vec};
      default: return {31'h0, b_spur};
    endcase
  endfunction
  // Monitor: compares every expectation scheduled for the cycle whose outputs are now settled.
  always @(negedge clk) begin : mon
    int i;
    logic [31:0] a;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc == cyc) begin
        a = act(sb[i].f);
        n_chk++;
        if (a !== sb[i].v) begin
          n_fail++;
          $display("FAIL %s @cyc %0d: got %0h expected %0h", sb[i].nm, cyc, a, sb[i].v);
        end
        sb.delete(i);
      end else i++;
    end
  end
  task automatic want(input int f, input logic [31:0] v, input int d, input string nm);
    ent_t e;
    e.cyc = cyc + d;
    e.f = f;
    e.v = v;
    e.nm = nm;
    sb.push_back(e);
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    rst = 1; irq = 0; mask = 0; lvl = 0; smm = 0; rot = 0; ack = 0;
    eoi_ns = 0; eoi_sp = 0; setp = 0; lvl_id = 0;
    b_irq = 0; b_ack = 0; b_eoi_sp = 0; b_setp = 0; b_lvl = 0;
    step(2);
    rst = 0;
    want(0, 8'h00, 0, "rst_irr"); want(1, 8'h00, 0, "rst_isr"); want(2, 0, 0, "rst_req");
    want(3, 0, 0, "rst_vec"); want(4, 0, 0, "rst_spur"); want(6, 0, 0, "rst_isr16");
    step();
    irq = 8'h28;
    want(0, 8'h28, 1, "t1_irr"); want(2, 0, 1, "t1_req_lat"); want(2, 1, 2, "t1_req");
    step(3);
    ack = 1; step(); ack = 0;
    want(3, 3, 0, "t1_vec"); want(1, 8'h08, 0, "t1_isr"); want(0, 8'h20, 0, "t1_irr_clr");
    want(4, 0, 0, "t1_spur"); want(2, 0, 1, "t1_req_drop");
    irq = 8'h2A;
    want(0, 8'h22, 1, "t2_irr"); want(2, 1, 2, "t2_req_bit1");
    step(2);
    ack = 1; step(); ack = 0;
    want(3, 1, 0, "t2_vec1"); want(1, 8'h0A, 0, "t2_isr"); want(2, 0, 1, "t2_bit5_blocked");
    eoi_sp = 1; lvl_id = 1; step(); eoi_sp = 0;
    want(1, 8'h08, 0, "t2_eoi_sp"); want(2, 0, 1, "t2_req_still0");
    step();
    smm = 1;
    want(2, 1, 1, "t2_smm_req");
    step();
    ack = 1; step(); ack = 0;
    want(3, 5, 0, "t2_smm_vec"); want(1, 8'h28, 0, "t2_smm_isr"); want(0, 8'h00, 0, "t2_irr");
    smm = 0; eoi_ns = 1; step();
    want(1, 8'h20, 0, "t2_eoi_ns_hi");
    step(); eoi_ns = 0;
    want(1, 8'h00, 0, "t2_eoi_ns2");
    irq = 8'h29;
    want(0, 8'h01, 1, "t3_irr"); want(2, 1, 2, "t3_req");
    step(2);
    ack = 1; step(); ack = 0;
    want(3, 0, 0, "t3_vec0"); want(1, 8'h01, 0, "t3_isr");
    rot = 1; eoi_ns = 1; step(); eoi_ns = 0; rot = 0;
    want(1, 8'h00, 0, "t3_rot_isr");
    irq = 8'h28; step();
    irq = 8'hAB;
    want(0, 8'h83, 1, "t3_irr83"); want(2, 1, 2, "t3_req2");
    step(2);
    ack = 1; step(); ack = 0;
    want(3, 1, 0, "t3_rotated_vec"); want(1, 8'h02, 0, "t3_isr2"); want(0, 8'h81, 0, "t3_irr81");
    eoi_sp = 1; lvl_id = 1; step(); eoi_sp = 0;
    mask = 8'hFF;
    want(2, 0, 1, "t4_masked_req");
    step();
    ack = 1; step(); ack = 0;
    want(4, 1, 0, "t4_spur"); want(3, 7, 0, "t4_vec7"); want(1, 8'h00, 0, "t4_isr");
    want(0, 8'h81, 0, "t4_irr");
    mask = 0; rst = 1; irq = 0; step(); rst = 0;
    want(0, 8'h00, 0, "rst2_irr"); want(3, 0, 0, "rst2_vec"); want(4, 0, 0, "rst2_spur");
    irq = 8'h10; step(2);
    ack = 1; step(); ack = 0;
    want(3, 4, 0, "t5_vec4"); want(1, 8'h10, 0, "t5_isr10");
    irq = 8'h04;
    want(2, 1, 2, "t5_req2");
    step(2);
    ack = 1; eoi_sp = 1; lvl_id = 4; step(); ack = 0; eoi_sp = 0;
    want(1, 8'h04, 0, "t5_ack_eoi"); want(3, 2, 0, "t5_vec2"); want(0, 8'h00, 0, "t5_irr");
    rst = 1; irq = 0; step(); rst = 0;
    want(1, 8'h00, 0, "rst_mid_isr"); want(2, 0, 0, "rst_mid_req");
    b_irq = 16'h8001; b_setp = 1; b_lvl = 15; step(); b_setp = 0;
    want(5, 16'h8001, 0, "t6_irr"); want(7, 1, 1, "t6_req");
    step(2);
    b_ack = 1; step(); b_ack = 0;
    want(8, 0, 0, "t6_vec0"); want(6, 16'h0001, 0, "t6_isr"); want(9, 0, 0, "t6_spur");
    b_eoi_sp = 1; b_lvl = 0; b_irq = 16'h8000; step(); b_eoi_sp = 0;
    want(6, 16'h0000, 0, "t6_eoi");
    b_irq = 16'h8001; b_setp = 1; b_lvl = 14; step(); b_setp = 0;
    want(5, 16'h8001, 0, "t6_irr2");
    step();
    b_ack = 1; step(); b_ack = 0;
    want(8, 15, 0, "t6_wrap_vec15"); want(6, 16'h8000, 0, "t6_isr15");
    step(3);
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      n_fail += sb.size();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
